// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : edge_event_arbiter
//  Purpose  : Detects rising edges on N synchronised level inputs, latches
//             each as a pending event and serves pending events one at a time
//             to a single consumer over valid/ready with round-robin priority.
//  Ports    : clk        - system clock, all state updates on posedge
//             reset      - synchronous active-high reset
//             level      - [N-1:0] per-channel level inputs (already synced)
//             ovf_clr    - clears the sticky overflow flags
//             out_ready  - consumer accepts the offered event
//             out_valid  - an event is being offered
//             out_id     - [IDW-1:0] channel index of the offered event
//             pending    - [N-1:0] per-channel pending-event flags
//             overflow   - [N-1:0] sticky: edge arrived while still pending
//  Revision : 1.0 - initial release
// ============================================================================
module edge_event_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   level,
  input  logic           ovf_clr,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [IDW-1:0] out_id,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overflow
);

  typedef enum logic [1:0] {
    DET_ZERO = 2'd0,
    DET_EDGE = 2'd1,
    DET_ONE  = 2'd2
  } det_state_t;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_t;

  // --------------------------------------------------------------------------
  // Per-channel Moore edge detectors. The EDGE state lasts exactly one cycle,
  // so tick is a single-cycle strobe per rising edge.
  // --------------------------------------------------------------------------
  logic [N-1:0] tick;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_det
      det_state_t det_q;
      det_state_t det_d;

      always_ff @(posedge clk) begin
        if (reset) begin
          det_q <= DET_ZERO;
        end else begin
          det_q <= det_d;
        end
      end

      always_comb begin
        det_d = DET_ZERO;
        case (det_q)
          DET_ZERO: det_d = level[gi] ? DET_EDGE : DET_ZERO;
          DET_EDGE: det_d = level[gi] ? DET_ONE  : DET_ZERO;
          DET_ONE:  det_d = level[gi] ? DET_ONE  : DET_ZERO;
          default:  det_d = DET_ZERO;
        endcase
      end

      assign tick[gi] = (det_q == DET_EDGE);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Arbiter state
  // --------------------------------------------------------------------------
  arb_state_t     arb_q, arb_d;
  logic [IDW-1:0] out_id_q, out_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   overflow_q, overflow_d;

  // Handshake only counts while an event is actually offered.
  logic         hs;
  logic [N-1:0] hs_vec;

  assign hs = (arb_q == ARB_OFFER) && out_ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_hs
      assign hs_vec[gi] = hs && (out_id_q == IDW'(gi));
    end
  endgenerate

  // A new tick always wins over the handshake clear, so an edge landing in
  // the handshake cycle re-arms the channel instead of being lost. Overflow
  // is only raised when the older event is not being consumed this cycle.
  always_comb begin
    pending_d  = tick | (pending_q & ~hs_vec);
    overflow_d = (tick & pending_q & ~hs_vec) | (overflow_q & ~{N{ovf_clr}});
  end

  // --------------------------------------------------------------------------
  // Round-robin search: first pending channel starting at ptr, wrapping at N.
  // The index carries one extra bit so ptr+k (< 2N) never overflows before
  // the modulo-N correction.
  // --------------------------------------------------------------------------
  logic [IDW:0]   idx;
  logic           sel_found;
  logic [IDW-1:0] sel_id;

  always_comb begin
    idx       = '0;
    sel_found = 1'b0;
    sel_id    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(N)) begin
        idx = idx - (IDW+1)'(N);
      end
      if (!sel_found && pending_q[idx[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    arb_d    = arb_q;
    out_id_d = out_id_q;
    ptr_d    = ptr_q;
    case (arb_q)
      ARB_IDLE: begin
        if (sel_found) begin
          arb_d    = ARB_OFFER;
          out_id_d = sel_id;
        end
      end
      ARB_OFFER: begin
        if (out_ready) begin
          arb_d = ARB_IDLE;
          ptr_d = (out_id_q == IDW'(N-1)) ? '0 : out_id_q + IDW'(1);
        end
      end
      default: arb_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arb_q      <= ARB_IDLE;
      out_id_q   <= '0;
      ptr_q      <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      arb_q      <= arb_d;
      out_id_q   <= out_id_d;
      ptr_q      <= ptr_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = (arb_q == ARB_OFFER);
  assign out_id    = out_id_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_edge_event_arbiter
//  Purpose  : Directed self-checking bench for edge_event_arbiter (N=4).
//             Inputs change 1 time unit after a rising edge; outputs are
//             sampled at the same point, after the registers have settled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_edge_event_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk;
  logic           reset;
  logic [N-1:0]   level;
  logic           ovf_clr;
  logic           out_ready;
  logic           out_valid;
  logic [IDW-1:0] out_id;
  logic [N-1:0]   pending;
  logic [N-1:0]   overflow;

  int n_cmp;
  int n_err;

  edge_event_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .level     (level),
    .ovf_clr   (ovf_clr),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_id    (out_id),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_offer(input string tag, input logic [IDW-1:0] id);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_id"},    32'(out_id),    32'(id));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    level     = '0;
    ovf_clr   = 1'b0;
    out_ready = 1'b0;

    // ---------------- reset state ----------------
    cyc(2);
    check("rst_valid",    32'(out_valid), 32'd0);
    check("rst_id",       32'(out_id),    32'd0);
    check("rst_pending",  32'(pending),   32'h0);
    check("rst_overflow", 32'(overflow),  32'h0);
    reset = 1'b0;
    cyc(1);

    // ---------------- 1: single edge on channel 1 ----------------
    level     = 4'b0010;
    out_ready = 1'b1;
    cyc(1);                                   // detector in EDGE (tick)
    check("t1_pend_tick", 32'(pending), 32'h0);
    cyc(1);                                   // tick latched
    check("t1_pend",      32'(pending),   32'h2);
    check("t1_valid_lo",  32'(out_valid), 32'd0);
    cyc(1);                                   // offered; ready ignored while invalid
    expect_offer("t1_offer", 2'd1);
    check("t1_pend_hold", 32'(pending),   32'h2);
    cyc(1);                                   // handshake
    check("t1_pend_clr",  32'(pending),   32'h0);
    check("t1_valid_clr", 32'(out_valid), 32'd0);
    check("t1_ovf",       32'(overflow),  32'h0);

    // ---------------- 2a: channels 0,2,3 together, ptr=0 ----------------
    level = '0;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    level = 4'b1101;
    cyc(2);
    check("t2a_pend",  32'(pending), 32'hD);
    cyc(1); expect_offer("t2a_g0", 2'd0);
    cyc(1); check("t2a_gap", 32'(out_valid), 32'd0);
            check("t2a_pend1", 32'(pending), 32'hC);
    cyc(1); expect_offer("t2a_g1", 2'd2);
    cyc(2); expect_offer("t2a_g2", 2'd3);
    cyc(1); check("t2a_pend_end", 32'(pending), 32'h0);

    // ---------------- 2b: move ptr to 3 via a grant on ch2, repeat ----------------
    level = '0;
    cyc(1);
    level = 4'b0100;                          // one-cycle pulse still gives one tick
    cyc(1);
    level = '0;
    cyc(1);
    check("t2b_pulse_pend", 32'(pending), 32'h4);
    cyc(1); expect_offer("t2b_pre", 2'd2);
    cyc(1); check("t2b_pre_clr", 32'(pending), 32'h0);
    level = 4'b1101;
    cyc(3); expect_offer("t2b_g0", 2'd3);
    cyc(2); expect_offer("t2b_g1", 2'd0);
    cyc(2); expect_offer("t2b_g2", 2'd2);
    cyc(1); check("t2b_pend_end", 32'(pending), 32'h0);

    // ---------------- 3: overflow on channel 2 ----------------
    level     = '0;
    cyc(1);
    out_ready = 1'b0;
    level     = 4'b0100;
    cyc(1);
    level     = '0;
    cyc(1);                                   // pending[2] set
    level     = 4'b0100;
    cyc(1);                                   // offered id 2, second tick now
    expect_offer("t3_offer", 2'd2);
    cyc(1);                                   // tick while pending, no handshake
    check("t3_ovf",  32'(overflow), 32'h4);
    check("t3_pend", 32'(pending),  32'h4);
    expect_offer("t3_hold", 2'd2);
    level     = '0;
    out_ready = 1'b1;
    cyc(1);                                   // single merged grant
    check("t3_pend_clr", 32'(pending),   32'h0);
    check("t3_valid_lo", 32'(out_valid), 32'd0);
    cyc(1);
    check("t3_no_regrant", 32'(out_valid), 32'd0);
    check("t3_ovf_sticky", 32'(overflow),  32'h4);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'h0);

    // ---------------- 4: tick on ch1 in its own handshake cycle ----------------
    out_ready = 1'b0;
    level     = 4'b0010;
    cyc(1);
    level     = '0;
    cyc(2);                                   // ptr=3 -> search 3,0,1
    expect_offer("t4_offer", 2'd1);
    level     = 4'b0010;
    cyc(1);                                   // detector now in EDGE
    out_ready = 1'b1;
    level     = '0;
    cyc(1);                                   // handshake and tick coincide
    check("t4_pend_keep", 32'(pending),   32'h2);
    check("t4_ovf",       32'(overflow),  32'h0);
    check("t4_valid_lo",  32'(out_valid), 32'd0);
    cyc(1); expect_offer("t4_regrant", 2'd1);
    cyc(1); check("t4_pend_clr", 32'(pending), 32'h0);

    // ---------------- 5: reset while offering ch3 ----------------
    out_ready = 1'b0;
    level     = 4'b1000;
    cyc(3);
    expect_offer("t5_offer", 2'd3);
    reset = 1'b1;
    cyc(1);
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_pend",  32'(pending),   32'h0);
    check("t5_rst_id",    32'(out_id),    32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    cyc(1);                                   // level still high -> EDGE
    check("t5_tick_pend", 32'(pending), 32'h0);
    cyc(1);
    check("t5_pend",      32'(pending),   32'h8);
    check("t5_valid_lo",  32'(out_valid), 32'd0);
    cyc(1); expect_offer("t5_grant", 2'd3);
    cyc(1); check("t5_pend_clr", 32'(pending), 32'h0);

    // ---------------- 6: hold all high, serve initial edges, then quiet ----------------
    level = 4'b1111;                          // ch3 already high: no new edge
    cyc(2);
    check("t6_pend", 32'(pending), 32'h7);
    cyc(1); expect_offer("t6_g0", 2'd0);      // ptr=0 after the ch3 grant
    cyc(2); expect_offer("t6_g1", 2'd1);
    cyc(2); expect_offer("t6_g2", 2'd2);
    cyc(1);
    for (int i = 0; i < 8; i++) begin
      check("t6_quiet_pend",  32'(pending),   32'h0);
      check("t6_quiet_valid", 32'(out_valid), 32'd0);
      cyc(1);
    end
    check("t6_ovf", 32'(overflow), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
